// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder built from two half-adder stages, with a
// registered carry, sums two WIDTH-bit operands LSB-first under start/busy/done.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// Handshake: start is sampled on the rising edge and accepted only in IDLE or
// DONE; busy is high for exactly WIDTH cycles after the accepting edge; done is
// a one-cycle pulse in the cycle S/C first carry the new result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  logic s1, c1, sbit, c2, cout;
  logic accept;

  half_adder u_ha_ab (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .s_o (s1),
    .c_o (c1)
  );

  half_adder u_ha_cin (
    .a_i (s1),
    .b_i (carry_q),
    .s_o (sbit),
    .c_o (c2)
  );

  assign cout = c1 | c2;

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_d = sbit;
    end else begin : g_res_wide
      assign res_d = {sbit, res_q[WIDTH-1:1]};
    end
  endgenerate

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else if (accept) begin
      state_q <= ADD;
      a_q     <= A;
      b_q     <= B;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ADD: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= cout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            s_q     <= res_d;
            c_q     <= cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign S           = s_q;
  assign C           = c_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1: directed cases with literal
// results plus randomized traffic against a cycle-level arithmetic model.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];

  logic       busy8, done8, c8;
  logic [7:0] s8;
  logic [1:0] dbg8;
  logic       busy1, done1, c1;
  logic [0:0] s1;
  logic [1:0] dbg1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (st[0]),
    .A           (av[0]),
    .B           (bv[0]),
    .busy        (busy8),
    .done        (done8),
    .S           (s8),
    .C           (c8),
    .dbg_state_o (dbg8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (st[1]),
    .A           (av[1][0:0]),
    .B           (bv[1][0:0]),
    .busy        (busy1),
    .done        (done1),
    .S           (s1),
    .C           (c1),
    .dbg_state_o (dbg1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  logic [8:0] last8;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference model: remaining busy cycles, pending sum, visible result.
  int         rem[2];
  logic       mdone[2];
  logic [8:0] mres[2];
  logic [8:0] pend[2];
  int         wid[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rem[d]   = 0;
        mdone[d] = 1'b0;
        mres[d]  = '0;
      end else if (rem[d] != 0) begin
        rem[d]   = rem[d] - 1;
        mdone[d] = (rem[d] == 0);
        if (rem[d] == 0) mres[d] = pend[d];
      end else begin
        mdone[d] = 1'b0;
        if (st[d]) begin
          rem[d] = wid[d];
          if (d == 0) pend[d] = 9'(av[d]) + 9'(bv[d]);
          else        pend[d] = 9'(av[d][0]) + 9'(bv[d][0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", busy8, rem[0] != 0);
      check("done8", done8, mdone[0]);
      check("sum8",  {c8, s8}, mres[0]);
      check("busy1", busy1, rem[1] != 0);
      check("done1", done1, mdone[1]);
      check("sum1",  {c1, s1}, mres[1]);
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [8:0] exp, input string tag);
    int  n;
    bit  seen;
    @(negedge clk);
    st[0] = 1'b1; av[0] = a; bv[0] = b;
    seen = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        st[0] = 1'b0; av[0] = 8'($urandom); bv[0] = 8'($urandom);
        check({tag, "_hold"}, {c8, s8}, last8);
      end
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_lat"}, seen ? n - 1 : 99, 8);
    check({tag, "_sum"}, {c8, s8}, exp);
    last8 = exp;
    @(negedge clk);
    check({tag, "_pulse"}, done8, 0);
  endtask

  task automatic run1(input logic a, input logic b, input logic [1:0] exp, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    st[1] = 1'b1; av[1] = {7'b0, a}; bv[1] = {7'b0, b};
    seen = 1'b0;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) st[1] = 1'b0;
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_lat"}, seen ? n - 1 : 99, 1);
    check({tag, "_sum"}, {c1, s1}, exp);
  endtask

  initial begin
    int n, first, second;
    wid[0] = 8; wid[1] = 1;
    for (int d = 0; d < 2; d++) begin
      rem[d] = 0; mdone[d] = 1'b0; mres[d] = '0; pend[d] = '0;
      st[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    last8 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8",  {c8, s8}, 0);
    check("rst_busy1", busy1, 0);
    check("rst_sum1",  {c1, s1}, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    run8(8'h0F, 8'h01, 9'h010, "t0f01");
    run8(8'hFF, 8'h01, 9'h100, "tff01");
    run8(8'hFF, 8'hFF, 9'h1FE, "tffff");
    run8(8'h00, 8'h00, 9'h000, "t0000");

    // Second start during ADD must be ignored.
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h55; bv[0] = 8'hAA;
    first = 99;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) st[0] = 1'b0;
      if (n == 3) begin st[0] = 1'b1; av[0] = 8'h01; bv[0] = 8'h01; end
      if (n == 4) st[0] = 1'b0;
      if (done8) begin first = n - 1; break; end
    end
    check("ign_lat", first, 8);
    check("ign_sum", {c8, s8}, 9'h0FF);
    last8 = 9'h0FF;

    // Reset in busy cycle 4 aborts with no done pulse.
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h12; bv[0] = 8'h34;
    for (n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) st[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum",  {c8, s8}, 0);
    rst = 1'b0;
    last8 = '0;
    first = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) first++;
    end
    check("abort_nodone", first, 0);
    run8(8'h3C, 8'h4A, 9'h086, "post_rst");

    // Start held through DONE: back-to-back with no idle gap.
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h03; bv[0] = 8'h04;
    first = -1; second = -1;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin av[0] = 8'h80; bv[0] = 8'h80; end
      if (first >= 0 && n == first + 1) begin
        st[0] = 1'b0;
        check("b2b_nogap", busy8, 1);
      end
      if (done8) begin
        if (first < 0) begin
          first = n;
          check("b2b_sum1", {c8, s8}, 9'h007);
        end else begin
          second = n;
          break;
        end
      end
    end
    check("b2b_spacing", second - first, 9);
    check("b2b_sum2", {c8, s8}, 9'h100);
    st[0] = 1'b0;
    last8 = 9'h100;

    run1(1'b0, 1'b0, 2'b00, "w1_00");
    run1(1'b0, 1'b1, 2'b01, "w1_01");
    run1(1'b1, 1'b0, 2'b01, "w1_10");
    run1(1'b1, 1'b1, 2'b10, "w1_11");

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      st[0] = ($urandom_range(0, 3) == 0);
      st[1] = ($urandom_range(0, 2) == 0);
      av[0] = 8'($urandom); bv[0] = 8'($urandom);
      av[1] = 8'($urandom); bv[1] = 8'($urandom);
      rst   = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    rst = 1'b0; st[0] = 1'b0; st[1] = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
